// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types: bundle geometry, queue payloads and PC helpers.
package fetch_unit_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned FETCH_WIDTH      = 2;
    localparam int unsigned FQ_DEPTH_DEFAULT = 4;
    localparam int unsigned BUNDLE_BYTES     = FETCH_WIDTH * 4;

    typedef logic [FETCH_WIDTH-1:0] slot_mask_t;

    // One decoded-width bundle as buffered in the fetch queue.
    typedef struct packed {
        slot_mask_t                        mask;
        logic [FETCH_WIDTH-1:0][XLEN-1:0]  pc;
        logic [FETCH_WIDTH-1:0][XLEN-1:0]  instr;
    } fetch_bundle_t;

    // Per-request tag carried alongside an outstanding memory request.
    typedef struct packed {
        slot_mask_t      mask;
        logic [XLEN-1:0] addr;
    } fetch_tag_t;

    function automatic logic [XLEN-1:0] bundle_align(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(BUNDLE_BYTES - 1);
    endfunction

    // Slots whose byte offset lies below the entry PC are not on the path.
    function automatic slot_mask_t start_mask(input logic [XLEN-1:0] pc);
        slot_mask_t m;
        m = '0;
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            m[i] = (XLEN'(4 * i) >= (pc & XLEN'(BUNDLE_BYTES - 1)));
        end
        return m;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; payload type is a parameter so the same
// block serves both the bundle queue and the in-flight tag queue.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter type         T     = fetch_bundle_t,
    parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           empty;
    logic           full;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Front-end fetch stage: issues aligned bundle requests under a credit
// limit, buffers in-order responses and presents one bundle per cycle.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     FQ_DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          imem_req_valid,
    input  logic                          imem_req_ready,
    output logic [XLEN-1:0]               imem_req_addr,
    input  logic                          imem_resp_valid,
    input  logic [XLEN*FETCH_WIDTH-1:0]   imem_resp_data,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic [FETCH_WIDTH-1:0]        if_valid,
    output logic [XLEN*FETCH_WIDTH-1:0]   if_pc,
    output logic [XLEN*FETCH_WIDTH-1:0]   if_instr,
    input  logic                          fetch_stall_req
);

    localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_addr;
    logic            first_req;
    logic [CW-1:0]   fq_count;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop_cnt;
    logic [CW:0]     credit_used;
    logic            req_fire;
    logic            resp_drop;
    logic            fq_push;
    logic            fq_pop;
    logic            fq_empty;

    fetch_tag_t      tag_push;
    fetch_tag_t      tag_head;
    fetch_bundle_t   bundle_in;
    fetch_bundle_t   bundle_head;

    assign req_addr    = bundle_align(fetch_pc);
    assign credit_used = (CW+1)'(fq_count) + (CW+1)'(inflight);

    assign imem_req_valid = !reset && !redirect_valid && (credit_used < (CW+1)'(FQ_DEPTH));
    assign imem_req_addr  = reset ? '0 : req_addr;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign tag_push.mask = first_req ? start_mask(fetch_pc) : '1;
    assign tag_push.addr = req_addr;

    assign resp_drop = (drop_cnt != '0);
    assign fq_push   = imem_resp_valid && !resp_drop && !redirect_valid;
    assign fq_empty  = (fq_count == '0);
    assign fq_pop    = !fq_empty && !fetch_stall_req;

    // Outstanding-request tags; occupancy doubles as the in-flight count.
    // Never flushed: stale responses still arrive and must retire their tag.
    fetch_queue #(
        .T     (fetch_tag_t),
        .DEPTH (FQ_DEPTH)
    ) u_tag_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (tag_push),
        .pop       (imem_resp_valid),
        .head      (tag_head),
        .count     (inflight)
    );

    fetch_queue #(
        .T     (fetch_bundle_t),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (fq_push),
        .push_data (bundle_in),
        .pop       (fq_pop),
        .head      (bundle_head),
        .count     (fq_count)
    );

    // Assemble the incoming bundle from the response and its tag.
    always_comb begin
        bundle_in.mask = tag_head.mask;
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            bundle_in.pc[i]    = tag_head.addr + XLEN'(4 * i);
            bundle_in.instr[i] = imem_resp_data[i*XLEN +: XLEN];
        end
    end

    // Next request address and the start-mask flag for the first bundle.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            first_req <= 1'b1;
        end else if (redirect_valid) begin
            fetch_pc  <= redirect_pc;
            first_req <= 1'b1;
        end else if (req_fire) begin
            fetch_pc  <= req_addr + XLEN'(BUNDLE_BYTES);
            first_req <= 1'b0;
        end
    end

    // Stale-response counter. On redirect every outstanding response is on
    // the old path; drop_cnt is already a subset of inflight, so it is
    // replaced by the post-cycle outstanding count rather than added to.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            drop_cnt <= inflight - CW'(imem_resp_valid);
        end else if (imem_resp_valid && resp_drop) begin
            drop_cnt <= drop_cnt - 1'b1;
        end
    end

    // Decode-facing outputs: head of the queue, zero when empty or in reset.
    always_comb begin
        if_valid = '0;
        if_pc    = '0;
        if_instr = '0;
        if (!reset && !fq_empty) begin
            if_valid = bundle_head.mask;
            for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
                if_pc[i*XLEN +: XLEN]    = bundle_head.pc[i];
                if_instr[i*XLEN +: XLEN] = bundle_head.instr[i];
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with random
// latency plus a path/epoch reference of what decode should receive.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int unsigned FW     = FETCH_WIDTH;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] BMASK  = 32'(FW * 4 - 1);
    localparam logic [31:0] BYTES  = 32'(FW * 4);

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 imem_req_valid;
    logic                 imem_req_ready;
    logic [31:0]          imem_req_addr;
    logic                 imem_resp_valid;
    logic [FW*32-1:0]     imem_resp_data;
    logic                 redirect_valid;
    logic [31:0]          redirect_pc;
    logic [FW-1:0]        if_valid;
    logic [FW*32-1:0]     if_pc;
    logic [FW*32-1:0]     if_instr;
    logic                 fetch_stall_req;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (RST_PC),
        .FQ_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .fetch_stall_req (fetch_stall_req)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    req_t        pend[$];
    int          cyc = 0;
    int          epoch = 0;
    int          fq_model = 0;
    int          last_due = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          n_pops = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] exp_req_pc = RST_PC;
    logic        exp_first = 1'b1;

    logic             s_req_valid;
    logic [31:0]      s_req_addr;
    logic [FW-1:0]    s_if_valid;
    logic [FW*32-1:0] s_if_pc;
    logic [FW*32-1:0] s_if_instr;
    logic             s_resp;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // One clock cycle: drive inputs, check outputs against the reference,
    // then advance the reference by what happened at the edge.
    task automatic step(input logic rst, input logic rdy, input logic stl,
                        input logic rdv, input logic [31:0] rpc);
        logic [FW-1:0]    ev;
        logic [FW*32-1:0] epc;
        logic [FW*32-1:0] ein;
        logic [31:0]      p;
        logic             exp_rv;
        logic             hs;
        logic             pop;
        int               resp_epoch;
        int               due;
        reset           = rst;
        imem_req_ready  = rdy;
        fetch_stall_req = stl;
        redirect_valid  = rdv;
        redirect_pc     = rpc;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            for (int i = 0; i < FW; i++)
                imem_resp_data[i*32 +: 32] = mem_word(pend[0].addr + 32'(4 * i));
        end
        exp_rv = !rst && !rdv && ((pend.size() + fq_model) < DEPTH);
        ev = '0; epc = '0; ein = '0;
        if (!rst && fq_model > 0) begin
            for (int i = 0; i < FW; i++) begin
                p = (exp_pc & ~BMASK) + 32'(4 * i);
                ev[i] = !exp_first || (32'(4 * i) >= (exp_pc & BMASK));
                epc[i*32 +: 32] = p;
                ein[i*32 +: 32] = mem_word(p);
            end
        end
        @(negedge clk);
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_if_valid  = if_valid;
        s_if_pc     = if_pc;
        s_if_instr  = if_instr;
        s_resp      = imem_resp_valid;
        n_checks++;
        if (imem_req_valid !== exp_rv) begin
            n_errors++;
            $display("FAIL req_valid cyc=%0d: got %b expected %b", cyc, imem_req_valid, exp_rv);
        end
        if (rst) begin
            n_checks++;
            if (imem_req_addr !== 32'h0) begin
                n_errors++;
                $display("FAIL req_addr_reset cyc=%0d: got %h expected 0", cyc, imem_req_addr);
            end
        end else if (exp_rv) begin
            n_checks++;
            if (imem_req_addr !== (exp_req_pc & ~BMASK)) begin
                n_errors++;
                $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, imem_req_addr, exp_req_pc & ~BMASK);
            end
        end
        n_checks++;
        if (if_valid !== ev) begin
            n_errors++;
            $display("FAIL if_valid cyc=%0d: got %b expected %b", cyc, if_valid, ev);
        end
        n_checks++;
        if (if_pc !== epc) begin
            n_errors++;
            $display("FAIL if_pc cyc=%0d: got %h expected %h", cyc, if_pc, epc);
        end
        n_checks++;
        if (if_instr !== ein) begin
            n_errors++;
            $display("FAIL if_instr cyc=%0d: got %h expected %h", cyc, if_instr, ein);
        end
        n_checks++;
        if (pend.size() + fq_model > DEPTH) begin
            n_errors++;
            $display("FAIL credit cyc=%0d: got %0d outstanding expected <= %0d", cyc, pend.size() + fq_model, DEPTH);
        end
        @(posedge clk);
        hs = s_req_valid && rdy;
        if (rst) begin
            pend.delete();
            fq_model   = 0;
            epoch++;
            exp_pc     = RST_PC;
            exp_req_pc = RST_PC;
            exp_first  = 1'b1;
            last_due   = 0;
        end else begin
            resp_epoch = -1;
            if (s_resp) begin
                resp_epoch = pend[0].epoch;
                pend.delete(0);
            end
            pop = (fq_model > 0) && !stl;
            if (hs) begin
                due = cyc + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend.push_back('{s_req_addr, due, epoch});
                exp_req_pc = (exp_req_pc & ~BMASK) + BYTES;
            end
            if (rdv) begin
                epoch++;
                fq_model   = 0;
                exp_pc     = rpc;
                exp_req_pc = rpc;
                exp_first  = 1'b1;
            end else begin
                if (s_resp && resp_epoch == epoch) fq_model++;
                if (pop) begin
                    fq_model--;
                    n_pops++;
                    exp_pc    = (exp_pc & ~BMASK) + BYTES;
                    exp_first = 1'b0;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        n_checks++;
        if (s_req_valid !== 1'b0 || s_if_valid !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got req=%b if_valid=%b expected 0/0", s_req_valid, s_if_valid);
        end
        step(0, 1, 0, 0, 0);
        n_checks++;
        if (s_req_valid !== 1'b1 || s_req_addr !== RST_PC) begin
            n_errors++;
            $display("FAIL reset_first_req: got valid=%b addr=%h expected 1/%h", s_req_valid, s_req_addr, RST_PC);
        end
    endtask

    task automatic test_back_to_back();
        lat_min = 1; lat_max = 1;
        step(1, 1, 0, 0, 0);
        for (int k = 0; k < 14; k++) begin
            step(0, 1, 0, 0, 0);
            n_checks++;
            if (s_req_addr !== 32'(k * FW * 4)) begin
                n_errors++;
                $display("FAIL b2b_req_addr k=%0d: got %h expected %h", k, s_req_addr, 32'(k * FW * 4));
            end
            n_checks++;
            if (k >= 2) begin
                if (s_if_valid !== '1 || s_if_pc[31:0] !== 32'((k - 2) * FW * 4)) begin
                    n_errors++;
                    $display("FAIL b2b_bundle k=%0d: got valid=%b pc0=%h expected all/%h", k, s_if_valid, s_if_pc[31:0], 32'((k - 2) * FW * 4));
                end
            end else if (s_if_valid !== '0) begin
                n_errors++;
                $display("FAIL b2b_startup k=%0d: got valid=%b expected 0", k, s_if_valid);
            end
        end
    endtask

    task automatic test_stall();
        logic [FW-1:0]    h_v;
        logic [FW*32-1:0] h_pc;
        logic [FW*32-1:0] h_in;
        h_v = '0; h_pc = '0; h_in = '0;
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 1, 0, 0);
            if (k == 0) begin
                h_v = s_if_valid; h_pc = s_if_pc; h_in = s_if_instr;
            end else begin
                n_checks++;
                if (s_if_valid !== h_v || s_if_pc !== h_pc || s_if_instr !== h_in) begin
                    n_errors++;
                    $display("FAIL stall_hold k=%0d: got %b/%h expected %b/%h", k, s_if_valid, s_if_pc, h_v, h_pc);
                end
            end
        end
        n_checks++;
        if (s_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_credit: got req_valid=%b expected 0", s_req_valid);
        end
        step(0, 1, 0, 0, 0);
        n_checks++;
        if (s_if_pc !== h_pc || s_if_valid !== h_v) begin
            n_errors++;
            $display("FAIL stall_release: got %h expected %h", s_if_pc, h_pc);
        end
        for (int k = 0; k < 10; k++) step(0, 1, 0, 0, 0);
    endtask

    task automatic test_redirect_inflight();
        int found;
        lat_min = 6; lat_max = 6;
        step(1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0);
        n_checks++;
        if (pend.size() != 3) begin
            n_errors++;
            $display("FAIL redir_setup: got %0d in flight expected 3", pend.size());
        end
        step(0, 1, 0, 1, 32'h0000_0104);
        n_checks++;
        if (s_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL redir_no_req: got %b expected 0", s_req_valid);
        end
        step(0, 1, 0, 0, 0);
        n_checks++;
        if (s_if_valid !== '0 || s_req_valid !== 1'b1 || s_req_addr !== 32'h0000_0100) begin
            n_errors++;
            $display("FAIL redir_next: got valid=%b req=%b addr=%h expected 0/1/00000100", s_if_valid, s_req_valid, s_req_addr);
        end
        found = 0;
        for (int k = 0; k < 30 && found < 2; k++) begin
            step(0, 1, 0, 0, 0);
            if (s_if_valid !== '0) begin
                n_checks++;
                if (found == 0 && (s_if_valid !== 2'b10 || s_if_pc[32 +: 32] !== 32'h0000_0104)) begin
                    n_errors++;
                    $display("FAIL redir_first: got valid=%b pc1=%h expected 10/00000104", s_if_valid, s_if_pc[32 +: 32]);
                end else if (found == 1 && (s_if_valid !== 2'b11 || s_if_pc[31:0] !== 32'h0000_0108)) begin
                    n_errors++;
                    $display("FAIL redir_second: got valid=%b pc0=%h expected 11/00000108", s_if_valid, s_if_pc[31:0]);
                end
                found++;
            end
        end
        n_checks++;
        if (found != 2) begin
            n_errors++;
            $display("FAIL redir_timeout: got %0d bundles expected 2", found);
        end
        lat_min = 1; lat_max = 1;
    endtask

    task automatic test_redirect_collide();
        lat_min = 1; lat_max = 1;
        step(1, 1, 0, 0, 0);
        for (int k = 0; k < 6; k++) step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 32'h0000_2000);
        n_checks++;
        if (s_resp !== 1'b1 || s_if_valid === '0 || s_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL collide_cycle: got resp=%b valid=%b req=%b expected 1/nonzero/0", s_resp, s_if_valid, s_req_valid);
        end
        step(0, 1, 0, 0, 0);
        n_checks++;
        if (s_if_valid !== '0 || s_req_valid !== 1'b1 || s_req_addr !== 32'h0000_2000) begin
            n_errors++;
            $display("FAIL collide_next: got valid=%b req=%b addr=%h expected 0/1/00002000", s_if_valid, s_req_valid, s_req_addr);
        end
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        n_checks++;
        if (s_if_valid !== '1 || s_if_pc[31:0] !== 32'h0000_2000) begin
            n_errors++;
            $display("FAIL collide_refill: got valid=%b pc0=%h expected 11/00002000", s_if_valid, s_if_pc[31:0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        int          pops0;
        lat_min = 1; lat_max = 6;
        step(1, 1, 0, 0, 0);
        pops0 = n_pops;
        for (int k = 0; k < 2000; k++) begin
            rpc = 32'($urandom_range(0, 4095)) << 2;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
            step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 49) == 0, rpc);
        end
        n_checks++;
        if (n_pops - pops0 < 200) begin
            n_errors++;
            $display("FAIL random_progress: got %0d bundles expected >= 200", n_pops - pops0);
        end
        lat_min = 1; lat_max = 1;
    endtask

    task automatic test_reset_midstream();
        lat_min = 3; lat_max = 3;
        step(1, 1, 0, 0, 0);
        for (int k = 0; k < 8; k++) step(0, 1, 0, 0, 0);
        n_checks++;
        if (pend.size() == 0 || s_if_valid === '0) begin
            n_errors++;
            $display("FAIL midreset_setup: got inflight=%0d valid=%b expected busy", pend.size(), s_if_valid);
        end
        step(1, 1, 0, 0, 0);
        n_checks++;
        if (s_if_valid !== '0 || s_if_pc !== '0 || s_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_outputs: got valid=%b pc=%h req=%b expected 0", s_if_valid, s_if_pc, s_req_valid);
        end
        step(0, 1, 0, 0, 0);
        n_checks++;
        if (s_if_valid !== '0 || s_req_valid !== 1'b1 || s_req_addr !== RST_PC) begin
            n_errors++;
            $display("FAIL midreset_restart: got valid=%b req=%b addr=%h expected 0/1/%h", s_if_valid, s_req_valid, s_req_addr, RST_PC);
        end
        for (int k = 0; k < 10; k++) step(0, 1, 0, 0, 0);
    endtask

    initial begin
        reset           = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        fetch_stall_req = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_stall();
        test_redirect_inflight();
        test_redirect_collide();
        test_random();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
